// File: rtl/rv32i_pkg.sv
// rv32i_pkg -- shared encodings for the RV32I pipeline control blocks.
//   wbsel_e    : write-back source select carried in the ID/EX register
//   fwd_e      : operand forwarding select driven into the EX operand muxes
//   hz_state_e : hazard-controller state, exported on state_o
//   reg_match  : true when a consumer reads a real (non-x0) producer register
package rv32i_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10
  } wbsel_e;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FLUSH    = 2'd3
  } hz_state_e;

  // x0 is hard-wired to zero, so it never creates a dependency.
  function automatic logic reg_match(input logic [REG_W-1:0] a,
                                     input logic [REG_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// fwd_unit -- forwarding select for one EX operand.
// Only built when HAZARD_FORWARD_EN is defined; the non-forwarding build
// ties the selects to FWD_NONE and has no use for this module.
// Ports:
//   src        : source register read by the EX operand
//   dest_MEM   : destination in EX/MEM, regwen_MEM its write enable
//   dest_WB    : destination in MEM/WB, regwen_WB its write enable
//   sel        : FWD_MEM (10), FWD_WB (01) or FWD_NONE (00)
`ifdef HAZARD_FORWARD_EN
module fwd_unit
  import rv32i_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] dest_MEM,
  input  logic             regwen_MEM,
  input  logic [REG_W-1:0] dest_WB,
  input  logic             regwen_WB,
  output logic [1:0]       sel
);

  // The younger result in MEM wins over the older one in WB.
  always_comb begin
    sel = FWD_NONE;
    if (regwen_MEM && reg_match(dest_MEM, src)) begin
      sel = FWD_MEM;
    end else if (regwen_WB && reg_match(dest_WB, src)) begin
      sel = FWD_WB;
    end
  end

endmodule
`endif

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard detection, stall/flush control and
// operand forwarding for a 5-stage RV32I core.
// Build option: HAZARD_FORWARD_EN enables EX operand forwarding; without it
// any pending EX/MEM write to a register read in ID stalls the pipeline.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   src1_ID, src2_ID         : sources of the instruction in ID
//   src1_EX, src2_EX, dest_EX, regwen_EX, PCsel_EX, WBsel_EX : ID/EX contents
//   dest_MEM, regwen_MEM     : EX/MEM contents
//   dest_WB, regwen_WB       : MEM/WB contents
//   dmem_ready               : data memory finished its access this cycle
//   stall_IF/ID/EX, flush_ID, clear_EX : combinational pipeline controls
//   fwdA_EX, fwdB_EX         : EX operand forwarding selects
//   state_o                  : registered hazard class of the previous cycle
//   stall_cycles, flush_count: wrapping event counters
module hazard_ctrl
  import rv32i_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] src1_ID,
  input  logic [REG_W-1:0] src2_ID,
  input  logic [REG_W-1:0] src1_EX,
  input  logic [REG_W-1:0] src2_EX,
  input  logic [REG_W-1:0] dest_EX,
  input  logic             regwen_EX,
  input  logic             PCsel_EX,
  input  logic [1:0]       WBsel_EX,
  input  logic [REG_W-1:0] dest_MEM,
  input  logic             regwen_MEM,
  input  logic [REG_W-1:0] dest_WB,
  input  logic             regwen_WB,
  input  logic             dmem_ready,
  output logic             stall_IF,
  output logic             stall_ID,
  output logic             stall_EX,
  output logic             flush_ID,
  output logic             clear_EX,
  output logic [1:0]       fwdA_EX,
  output logic [1:0]       fwdB_EX,
  output logic [1:0]       state_o,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_count
);

  logic      mem_wait;
  logic      br_flush;
  logic      raw_hz;
  hz_state_e state;
  hz_state_e state_nxt;

  assign mem_wait = ~dmem_ready;
  // PCsel_EX stays asserted while memory stalls EX, so the flush is simply
  // taken in the first cycle memory is ready.
  assign br_flush = dmem_ready & PCsel_EX;

`ifdef HAZARD_FORWARD_EN
  logic load_EX;

  // Everything except a load result can be forwarded in time, so only a
  // load in EX feeding the instruction in ID costs a bubble.
  assign load_EX = regwen_EX & (WBsel_EX == WB_LOAD);
  assign raw_hz  = load_EX & (reg_match(dest_EX, src1_ID) |
                              reg_match(dest_EX, src2_ID));

  fwd_unit u_fwd_a (
    .src        (src1_EX),
    .dest_MEM   (dest_MEM),
    .regwen_MEM (regwen_MEM),
    .dest_WB    (dest_WB),
    .regwen_WB  (regwen_WB),
    .sel        (fwdA_EX)
  );

  fwd_unit u_fwd_b (
    .src        (src2_EX),
    .dest_MEM   (dest_MEM),
    .regwen_MEM (regwen_MEM),
    .dest_WB    (dest_WB),
    .regwen_WB  (regwen_WB),
    .sel        (fwdB_EX)
  );
`else
  logic unused_fwd_inputs;

  // The register file writes through, so a WB-stage producer is already
  // visible to ID; only EX and MEM producers have to be waited out.
  assign raw_hz = (regwen_EX  & (reg_match(dest_EX,  src1_ID) |
                                 reg_match(dest_EX,  src2_ID))) |
                  (regwen_MEM & (reg_match(dest_MEM, src1_ID) |
                                 reg_match(dest_MEM, src2_ID)));

  assign fwdA_EX = FWD_NONE;
  assign fwdB_EX = FWD_NONE;

  assign unused_fwd_inputs = ^{src1_EX, src2_EX, dest_WB, regwen_WB, WBsel_EX};
`endif

  // Priority: memory wait > branch flush > load-use stall.
  always_comb begin
    stall_IF  = 1'b0;
    stall_ID  = 1'b0;
    stall_EX  = 1'b0;
    flush_ID  = 1'b0;
    clear_EX  = 1'b0;
    state_nxt = ST_RUN;
    if (mem_wait) begin
      stall_IF  = 1'b1;
      stall_ID  = 1'b1;
      stall_EX  = 1'b1;
      state_nxt = ST_MEM_WAIT;
    end else if (br_flush) begin
      flush_ID  = 1'b1;
      clear_EX  = 1'b1;
      state_nxt = ST_FLUSH;
    end else if (raw_hz) begin
      stall_IF  = 1'b1;
      stall_ID  = 1'b1;
      clear_EX  = 1'b1;
      state_nxt = ST_LU_STALL;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  assign state_o = state;

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_IF) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (flush_ID) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end

endmodule
